// File: rtl/tpm_fifo_ctrl_if.sv
// rtl/tpm_fifo_ctrl_if.sv - host DATA_FIFO byte access bundle for tpm_fifo_ctrl
interface tpm_fifo_ctrl_if;
    logic       host_wr_i;
    logic [7:0] host_wdata_i;
    logic       host_rd_i;
    logic [7:0] host_rdata_o;
    logic       host_rvalid_o;
    logic       host_busy_o;

    modport master (
        output host_wr_i,
        output host_wdata_i,
        output host_rd_i,
        input  host_rdata_o,
        input  host_rvalid_o,
        input  host_busy_o
    );

    modport slave (
        input  host_wr_i,
        input  host_wdata_i,
        input  host_rd_i,
        output host_rdata_o,
        output host_rvalid_o,
        output host_busy_o
    );
endinterface

// File: rtl/tpm_fifo_ctrl.sv
// rtl/tpm_fifo_ctrl.sv - TPM_DATA_FIFO command/response sequencer and buffer RAM arbiter
module tpm_fifo_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int MIN_SIZE = 10
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    tpm_fifo_ctrl_if.slave      host,
    input  logic                cmd_ready_i,
    input  logic                go_i,
    input  logic                retry_i,
    input  logic                abort_i,
    output logic                expect_o,
    output logic                data_avail_o,
    output logic                cmd_ready_o,
    output logic [2:0]          state_o,
    output logic                exec_o,
    output logic [ADDR_W:0]     cmd_size_o,
    output logic                cancel_o,
    input  logic                mcu_done_i,
    input  logic [ADDR_W:0]     rsp_size_i,
    input  logic [ADDR_W-1:0]   mcu_addr_i,
    input  logic [7:0]          mcu_wdata_i,
    input  logic                mcu_we_i,
    output logic                buf_owner_mcu_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [7:0]          mem_wdata_o,
    output logic                mem_we_o,
    input  logic [7:0]          mem_rdata_i
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]    DEPTH_W = {{(32-AW1){1'b0}}, DEPTH_P};
    localparam logic [31:0]    MIN_W   = 32'(MIN_SIZE);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_READY      = 3'd1,
        S_RECEPTION  = 3'd2,
        S_FULL       = 3'd3,
        S_EXECUTION  = 3'd4,
        S_COMPLETION = 3'd5,
        S_ERROR      = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              expect_q, expect_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              avail_q, avail_d;
    logic              cancel_q, cancel_d;
    logic [AW1-1:0]    wptr_q, wptr_d;
    logic [AW1-1:0]    rptr_q, rptr_d;
    logic [AW1-1:0]    rsp_q, rsp_d;
    logic [31:0]       size_q, size_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              rd1_q, rd1_d, rd2_q, rd2_d;
    logic              real1_q, real1_d, real2_q, real2_d;

    logic              busy;
    logic [AW1-1:0]    rsp_clamp;

    assign busy      = rd1_q | rd2_q;
    assign rsp_clamp = (rsp_size_i > DEPTH_P) ? DEPTH_P : rsp_size_i;

    // Next-state and datapath decode, highest-priority event wins the cycle
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        cmd_rdy_d   = cmd_rdy_q;
        avail_d     = avail_q;
        cancel_d    = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rsp_d       = rsp_q;
        size_d      = size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rd1_d       = 1'b0;
        real1_d     = 1'b0;
        rd2_d       = rd1_q;
        real2_d     = real1_q;

        if (abort_i) begin
            state_d   = S_IDLE;
            expect_d  = 1'b0;
            cmd_rdy_d = 1'b0;
            avail_d   = 1'b0;
            cancel_d  = (state_q == S_EXECUTION);
        end else if (cmd_ready_i) begin
            if (state_q == S_IDLE) begin
                state_d   = S_READY;
                cmd_rdy_d = 1'b1;
                expect_d  = 1'b1;
                wptr_d    = '0;
                size_d    = '0;
            end else if (state_q != S_READY) begin
                state_d   = S_IDLE;
                expect_d  = 1'b0;
                cmd_rdy_d = 1'b0;
                avail_d   = 1'b0;
                cancel_d  = (state_q == S_EXECUTION);
            end
        end else if (go_i || retry_i || mcu_done_i) begin
            if (go_i && state_q == S_FULL) begin
                state_d = S_EXECUTION;
            end
            if (mcu_done_i && state_q == S_EXECUTION) begin
                state_d = S_COMPLETION;
                rsp_d   = rsp_clamp;
                rptr_d  = '0;
                avail_d = (rsp_clamp != '0);
            end
            if (retry_i && state_q == S_COMPLETION) begin
                rptr_d  = '0;
                avail_d = (rsp_q != '0);
            end
        end else if (!busy) begin
            if (host.host_wr_i) begin
                if ((state_q == S_READY || state_q == S_RECEPTION) && expect_q
                    && (wptr_q < DEPTH_P)) begin
                    mem_addr_d  = wptr_q[ADDR_W-1:0];
                    mem_wdata_d = host.host_wdata_i;
                    mem_we_d    = 1'b1;
                    wptr_d      = wptr_q + 1'b1;
                    state_d     = S_RECEPTION;
                    cmd_rdy_d   = 1'b0;
                    // Header bytes 2..5 carry commandSize, big-endian
                    if (wptr_q >= AW1'(2) && wptr_q <= AW1'(5)) begin
                        size_d = {size_q[23:0], host.host_wdata_i};
                    end
                    if (wptr_q == AW1'(5) && (size_d < MIN_W || size_d > DEPTH_W)) begin
                        expect_d = 1'b0;
                        state_d  = S_ERROR;
                    end else if (wptr_q >= AW1'(5)
                                 && {{(32-AW1){1'b0}}, wptr_d} == size_d) begin
                        expect_d = 1'b0;
                        state_d  = S_FULL;
                    end
                end
            end else if (host.host_rd_i && state_q != S_EXECUTION) begin
                rd1_d = 1'b1;
                if (state_q == S_COMPLETION && avail_q) begin
                    real1_d    = 1'b1;
                    mem_addr_d = rptr_q[ADDR_W-1:0];
                    rptr_d     = rptr_q + 1'b1;
                    if (rptr_d == rsp_q) begin
                        avail_d = 1'b0;
                    end
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            expect_q    <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            avail_q     <= 1'b0;
            cancel_q    <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            rsp_q       <= '0;
            size_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd1_q       <= 1'b0;
            rd2_q       <= 1'b0;
            real1_q     <= 1'b0;
            real2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            expect_q    <= expect_d;
            cmd_rdy_q   <= cmd_rdy_d;
            avail_q     <= avail_d;
            cancel_q    <= cancel_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rsp_q       <= rsp_d;
            size_q      <= size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            real1_q     <= real1_d;
            real2_q     <= real2_d;
        end
    end

    assign expect_o        = expect_q;
    assign data_avail_o    = avail_q;
    assign cmd_ready_o     = cmd_rdy_q;
    assign state_o         = state_q;
    assign exec_o          = (state_q == S_EXECUTION);
    assign buf_owner_mcu_o = exec_o;
    assign cmd_size_o      = exec_o ? size_q[ADDR_W:0] : '0;
    assign cancel_o        = cancel_q;

    // MCU drives the RAM port directly while it owns the buffer
    assign mem_addr_o  = exec_o ? mcu_addr_i  : mem_addr_q;
    assign mem_wdata_o = exec_o ? mcu_wdata_i : mem_wdata_q;
    assign mem_we_o    = exec_o ? mcu_we_i    : mem_we_q;

    assign host.host_rvalid_o = rd2_q;
    assign host.host_busy_o   = busy;
    assign host.host_rdata_o  = (rd2_q && real2_q) ? mem_rdata_i : 8'hFF;

endmodule

// File: doc/tpm_fifo_ctrl.md
Name: tpm_fifo_ctrl

Overview:
- Sequences the TPM_DATA_FIFO command/response buffer behind the TPM register block.
- Accepts host byte writes and reads decoded from DATA_FIFO accesses, and tracks the command header to produce Expect, dataAvail and commandReady status.
- Hands buffer ownership to the MCU between tpmGo and response completion, and arbitrates the single-port buffer RAM between host and MCU.

Parameters:
ADDR_W, 11, buffer address width; DEPTH = 2**ADDR_W bytes.
MIN_SIZE, 10, smallest legal commandSize in bytes (TPM 2.0 header length).

Ports:
clk_i  in  1  host-interface clock; the only clock.
rst_n_i  in  1  asynchronous active-low reset.
host_wr_i  in  1  one-cycle pulse: DATA_FIFO byte write.
host_wdata_i  in  8  write byte.
host_rd_i  in  1  one-cycle pulse: DATA_FIFO byte read.
host_rdata_o  out  8  read byte.
host_rvalid_o  out  1  one-cycle pulse: host_rdata_o valid.
host_busy_o  out  1  read in flight; new host_rd_i/host_wr_i are ignored.
cmd_ready_i  in  1  pulse: commandReady=1 written to TPM_STS.
go_i  in  1  pulse: tpmGo written.
retry_i  in  1  pulse: responseRetry written.
abort_i  in  1  pulse: locality change or seize; cancels the command.
expect_o  out  1  TPM_STS.Expect.
data_avail_o  out  1  TPM_STS.dataAvail.
cmd_ready_o  out  1  TPM_STS.commandReady.
state_o  out  3  current state encoding, for the register block.
exec_o  out  1  level: command available to MCU (EXECUTION state).
cmd_size_o  out  ADDR_W+1  received commandSize, valid while exec_o=1.
cancel_o  out  1  one-cycle pulse to MCU: execution aborted.
mcu_done_i  in  1  pulse: response written to buffer.
rsp_size_i  in  ADDR_W+1  response byte count, sampled with mcu_done_i.
mcu_addr_i  in  ADDR_W  MCU buffer address.
mcu_wdata_i  in  8  MCU write data.
mcu_we_i  in  1  MCU write enable.
buf_owner_mcu_o  out  1  1 = MCU owns RAM port.
mem_addr_o  out  ADDR_W  RAM address.
mem_wdata_o  out  8  RAM write data.
mem_we_o  out  1  RAM write enable.
mem_rdata_i  in  8  RAM read data; synchronous RAM, 1-cycle latency.

Behaviour:
- Reset (asynchronous): state IDLE(0), all pointers and counters 0, all outputs 0 except host_rdata_o = 8'hFF.
- States: IDLE=0, READY=1, RECEPTION=2, FULL=3, EXECUTION=4, COMPLETION=5, ERROR=6.
- Event priority within a cycle: abort_i > cmd_ready_i > go_i/retry_i/mcu_done_i > host_wr_i/host_rd_i. A lower-priority event in the same cycle is dropped.
- abort_i: any state -> IDLE, all flags cleared. If the state was EXECUTION, cancel_o pulses in the next cycle.
- cmd_ready_i:
  - IDLE -> READY; cmd_ready_o=1, expect_o=1, wptr=0.
  - READY: no change.
  - RECEPTION, FULL, ERROR, EXECUTION, COMPLETION -> IDLE; flags cleared. From EXECUTION, cancel_o also pulses.
- host_wr_i, accepted only in READY or RECEPTION with expect_o=1:
  - RAM[wptr] <= byte (mem_we_o asserted the following cycle); wptr++.
  - READY -> RECEPTION; cmd_ready_o cleared.
  - Bytes 2..5 form commandSize, big-endian.
  - On the 6th byte, if size < MIN_SIZE or size > DEPTH: expect_o=0, state -> ERROR.
  - When wptr reaches size: expect_o=0, state -> FULL.
  - Writes in any other state or with expect_o=0 are ignored.
- go_i: FULL -> EXECUTION. Ignored in every other state, including ERROR.
- EXECUTION:
  - buf_owner_mcu_o=1, exec_o=1.
  - mem_addr_o/mem_wdata_o/mem_we_o combinationally forward the mcu_* inputs.
  - Host writes and reads are ignored.
- mcu_done_i in EXECUTION:
  - rsp_size is clamped to DEPTH; rptr=0; state -> COMPLETION.
  - data_avail_o = (rsp_size != 0).
  - Ignored in every other state.
- host_rd_i in cycle N:
  - If in COMPLETION with data_avail_o=1: mem_addr_o=rptr registered at end of N; host_rvalid_o pulses in N+2 with host_rdata_o=RAM[rptr]; rptr++.
  - data_avail_o clears in N+1 when rptr+1 == rsp_size.
  - Otherwise host_rvalid_o pulses in N+2 with 8'hFF.
  - host_busy_o=1 during N+1..N+2.
  - An in-flight read completes even if abort_i or cmd_ready_i occurs.
- retry_i in COMPLETION: rptr=0, data_avail_o=(rsp_size!=0).
- wptr and rptr never wrap. No write is performed once wptr == DEPTH.

Test Plan:
- cmd_ready_i, then write 80 01 00 00 00 0C 00 00 01 44 00 00 -> expect_o falls after the 12th byte, state FULL(3); go_i -> exec_o=1, cmd_size_o=12, buf_owner_mcu_o=1.
- From EXECUTION, mcu_done_i with rsp_size_i=10, then 10 host reads -> bytes match RAM, each host_rvalid_o 2 cycles after host_rd_i; data_avail_o=0 after the 10th read; an 11th read returns FF.
- Header declaring size 4 -> ERROR(6), expect_o=0 after byte 6; go_i ignored; cmd_ready_i -> IDLE, then READY on a second pulse.
- abort_i during EXECUTION -> IDLE next cycle, cancel_o pulses once; abort_i and cmd_ready_i in the same cycle -> IDLE only.
- After reading 4 of 10 response bytes, retry_i -> the next read returns byte 0 and data_avail_o=1.
- Assert rst_n_i low mid-RECEPTION with no clock edge -> outputs go to reset values immediately; a later host_wr_i is ignored until cmd_ready_i.
